aurora_tx_arbiter: RTL and testbench
====================================

Name: aurora_tx_arbiter

Overview:
- Shares the single Aurora streaming TX interface (TX_D / TX_SRC_RDY_N / TX_DST_RDY_N, active-low LocalLink-style) among N_SRC requesters in the user-clock domain.
- Grants whole bursts round-robin and prefixes each burst with one header word carrying a tag, the source index and the payload length.
- Streams the granted source's payload through to the link.
- Sits between application-level producers and the aurora8 core; gated by CHANNEL_UP.

Parameters:
- DATA_WIDTH, 16, TX word width. Must be >= 16.
- N_SRC, 4, number of requesters. Range 2..16.
- LEN_WIDTH, 8, payload-length field width. Must be <= 8.

Ports:
- USER_CLK  in  1  Aurora user clock; all logic is on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- CHANNEL_UP  in  1  Aurora channel status.
- REQ  in  N_SRC  per-source burst request, level.
- REQ_LEN  in  N_SRC*LEN_WIDTH  per-source payload word count. Source i uses bits [i*LEN_WIDTH +: LEN_WIDTH].
- GNT  out  N_SRC  one-hot grant, held for the whole burst.
- SRC_D  in  N_SRC*DATA_WIDTH  per-source payload word. Source i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- SRC_VALID  in  N_SRC  per-source payload word valid.
- SRC_POP  out  N_SRC  per-source word consumed this cycle.
- TX_D  out  [0:DATA_WIDTH-1]  to aurora8 TX_D.
- TX_SRC_RDY_N  out  1  to aurora8, active-low.
- TX_DST_RDY_N  in  1  from aurora8, active-low.
- BURST_DONE  out  1  one-cycle pulse after the last word of a burst transfers.
- BURST_ABORT  out  1  one-cycle pulse when a burst is cut by CHANNEL_UP loss.
- CUR_SRC  out  4  index of the latched source.

Behaviour:
- Interface decisions:
  - One clock, USER_CLK.
  - RESET is synchronous and active-high.
- Reset values:
  - TX_SRC_RDY_N=1, TX_D=0, GNT=0, SRC_POP=0.
  - BURST_DONE=0, BURST_ABORT=0, CUR_SRC=0.
  - State=IDLE.
  - Round-robin pointer last=N_SRC-1, so source 0 wins first.
- Transfer rule: a word transfers on a cycle where TX_SRC_RDY_N=0 and TX_DST_RDY_N=0.
- State IDLE:
  - TX_SRC_RDY_N=1, GNT=0.
  - If CHANNEL_UP=1 and |REQ: select the first requesting index searching last+1, last+2, ... modulo N_SRC.
  - Latch sel into CUR_SRC, latch REQ_LEN[sel] into the counter, set last=sel, go to HDR.
  - IDLE always lasts at least one cycle, so there are no back-to-back grants.
- State HDR:
  - GNT[sel]=1.
  - TX_D is registered: bits [DATA_WIDTH-1:DATA_WIDTH-16] = {4'hA, sel[3:0], len zero-extended to 8 bits}; remaining low bits are 0.
  - TX_D bit 0 in MSB-first [0:N] numbering is the tag MSB.
  - TX_SRC_RDY_N=0.
  - On transfer: go to DATA if len!=0. If len=0, go to IDLE and pulse BURST_DONE on the next cycle.
  - The header is held stable until it transfers.
- State DATA:
  - GNT[sel]=1.
  - TX_D = SRC_D slice of sel, combinational passthrough.
  - TX_SRC_RDY_N = ~SRC_VALID[sel].
  - SRC_POP[sel] = SRC_VALID[sel] & ~TX_DST_RDY_N. All other SRC_POP bits are 0.
  - The counter decrements on each transfer. On the transfer with counter==1: go to IDLE and pulse BURST_DONE on the next cycle.
  - SRC_VALID gaps insert idle cycles; they are not an error.
- Requests during a burst:
  - REQ and REQ_LEN changes after the latch are ignored.
  - Deasserting REQ[sel] mid-burst does not shorten the burst.
- CHANNEL_UP=0 while in HDR or DATA:
  - The same cycle forces TX_SRC_RDY_N=1 and SRC_POP=0.
  - The next state is IDLE, with GNT=0.
  - BURST_ABORT pulses for one cycle.
  - The pointer stays advanced.
  - No partial burst resumes.
- CHANNEL_UP=0 in IDLE: no grant is issued.
- RESET mid-burst: immediate return to the reset values; no BURST_DONE or BURST_ABORT is issued.
- Exactly one GNT bit is ever high. SRC_POP only ever goes high for the granted source.

Test Plan:
- Reset, CHANNEL_UP=1, REQ=4'b0001, len=3, SRC_VALID=1, TX_DST_RDY_N=0 -> header 16'hA003, then 3 payload words on consecutive cycles, BURST_DONE one cycle after the last word, GNT=4'b0001 for exactly 4 cycles.
- REQ=4'b1111 held, all len=1 -> grant order 0,1,2,3,0, each burst 2 words plus at least 1 idle cycle, headers A001, A101, A201, A301.
- len=4 on source 2, TX_DST_RDY_N high for 3 cycles during the header and 2 cycles mid-payload -> header held stable, SRC_POP[2] low during stalls, exactly 4 pops total, header 16'hA204.
- len=0 on source 1 -> header 16'hA100 only, no SRC_POP, BURST_DONE pulses.
- Drop CHANNEL_UP after 2 of 5 payload words -> TX_SRC_RDY_N=1 that cycle, BURST_ABORT single pulse, GNT=0, no BURST_DONE; on restore the next grant goes to the next source in round-robin order.
- Assert RESET mid-burst -> all outputs take reset values on the next edge, and the first subsequent grant goes to source 0.

Source files
------------

// File: rtl/aurora_tx_arbiter.sv
// aurora_tx_arbiter
//
// Shares one Aurora LocalLink-style TX stream among N_SRC requesters in the
// USER_CLK domain. Whole bursts are granted round-robin. Each burst begins
// with one header word, {4'hA, source[3:0], length[7:0]}, placed in the top
// 16 bits of the word. The granted source's payload words then follow as a
// combinational pass-through. Losing CHANNEL_UP cuts the burst at once, and
// the cut burst is never resumed.
//
// Ports
//   USER_CLK      in   user clock, rising edge
//   RESET         in   synchronous, active-high
//   CHANNEL_UP    in   link status; a grant is issued only while it is high
//   REQ           in   [N_SRC]            per-source burst request (level)
//   REQ_LEN       in   [N_SRC*LEN_WIDTH]  per-source payload word count
//   GNT           out  [N_SRC]            one-hot grant, held for the burst
//   SRC_D         in   [N_SRC*DATA_WIDTH] per-source payload word
//   SRC_VALID     in   [N_SRC]            per-source payload word valid
//   SRC_POP       out  [N_SRC]            per-source word consumed this cycle
//   TX_D          out  [0:DATA_WIDTH-1]   to the Aurora core (bit 0 is the MSB)
//   TX_SRC_RDY_N  out  source ready to the Aurora core, active-low
//   TX_DST_RDY_N  in   destination ready from the Aurora core, active-low
//   BURST_DONE    out  one-cycle pulse after the last word of a burst
//   BURST_ABORT   out  one-cycle pulse after a burst is cut by link loss
//   CUR_SRC       out  [4] index of the latched source

module aurora_tx_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int N_SRC      = 4,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                          USER_CLK,
    input  logic                          RESET,
    input  logic                          CHANNEL_UP,
    input  logic [N_SRC-1:0]              REQ,
    input  logic [N_SRC*LEN_WIDTH-1:0]    REQ_LEN,
    output logic [N_SRC-1:0]              GNT,
    input  logic [N_SRC*DATA_WIDTH-1:0]   SRC_D,
    input  logic [N_SRC-1:0]              SRC_VALID,
    output logic [N_SRC-1:0]              SRC_POP,
    output logic [0:DATA_WIDTH-1]         TX_D,
    output logic                          TX_SRC_RDY_N,
    input  logic                          TX_DST_RDY_N,
    output logic                          BURST_DONE,
    output logic                          BURST_ABORT,
    output logic [3:0]                    CUR_SRC
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cur_q,   cur_d;
    logic [3:0]              last_q,  last_d;
    logic [LEN_WIDTH-1:0]    cnt_q,   cnt_d;
    logic [DATA_WIDTH-1:0]   hdr_q,   hdr_d;
    logic                    done_q,  done_d;
    logic                    abort_q, abort_d;

    logic [3:0]              sel;
    logic [LEN_WIDTH-1:0]    sel_len;
    logic                    cur_valid;
    logic [DATA_WIDTH-1:0]   cur_data;
    logic [DATA_WIDTH-1:0]   tx_word;
    logic                    tx_rdy_n;
    logic                    xfer;

    // The header occupies the top 16 bits of the word; any lower bits are zero.
    function automatic logic [DATA_WIDTH-1:0] make_header(input logic [3:0] src,
                                                          input logic [LEN_WIDTH-1:0] len);
        logic [DATA_WIDTH-1:0] w;
        w = '0;
        w[DATA_WIDTH-1 -: 16] = {4'hA, src, 8'(len)};
        return w;
    endfunction

    // Round-robin pick. The distance of source i from last+1 (modulo N_SRC)
    // sets its priority, and the requester at the smallest distance wins.
    always_comb begin
        int best_d;
        int d;
        sel     = last_q;
        sel_len = '0;
        best_d  = N_SRC;
        for (int i = 0; i < N_SRC; i++) begin
            d = i - int'(last_q) - 1;
            if (d < 0) d = d + N_SRC;
            if (REQ[i] && d < best_d) begin
                best_d = d;
                sel    = 4'(i);
            end
        end
        for (int i = 0; i < N_SRC; i++) begin
            if (sel == 4'(i)) sel_len = REQ_LEN[i*LEN_WIDTH +: LEN_WIDTH];
        end
    end

    // Mux the latched source's valid and data.
    always_comb begin
        cur_valid = 1'b0;
        cur_data  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (cur_q == 4'(i)) begin
                cur_valid = SRC_VALID[i];
                cur_data  = SRC_D[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Link-side outputs. Losing CHANNEL_UP drops ready and pops in the same
    // cycle, so no word can transfer while the link is down.
    always_comb begin
        tx_rdy_n = 1'b1;
        tx_word  = '0;
        GNT      = '0;
        SRC_POP  = '0;
        case (state_q)
            HDR: begin
                for (int i = 0; i < N_SRC; i++) GNT[i] = (cur_q == 4'(i));
                tx_word  = hdr_q;
                tx_rdy_n = ~CHANNEL_UP;
            end
            DATA: begin
                for (int i = 0; i < N_SRC; i++) begin
                    GNT[i]     = (cur_q == 4'(i));
                    SRC_POP[i] = (cur_q == 4'(i)) & cur_valid & ~TX_DST_RDY_N & CHANNEL_UP;
                end
                tx_word  = cur_data;
                tx_rdy_n = ~(cur_valid & CHANNEL_UP);
            end
            default: ;
        endcase
    end

    assign xfer         = ~tx_rdy_n & ~TX_DST_RDY_N;
    assign TX_D         = tx_word;
    assign TX_SRC_RDY_N = tx_rdy_n;
    assign BURST_DONE   = done_q;
    assign BURST_ABORT  = abort_q;
    assign CUR_SRC      = cur_q;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        hdr_d   = hdr_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (CHANNEL_UP && (|REQ)) begin
                    cur_d   = sel;
                    last_d  = sel;
                    cnt_d   = sel_len;
                    hdr_d   = make_header(sel, sel_len);
                    state_d = HDR;
                end
            end
            HDR: begin
                if (!CHANNEL_UP) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else if (xfer) begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (!CHANNEL_UP) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else if (xfer) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == LEN_WIDTH'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge USER_CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            cur_q   <= 4'd0;
            last_q  <= 4'(N_SRC - 1);
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    // The length counter and header word are only read outside IDLE, and
    // both are loaded when a grant is issued, so they are left out of reset.
    always_ff @(posedge USER_CLK) begin
        cnt_q <= cnt_d;
        hdr_q <= hdr_d;
    end

endmodule

// File: tb/tb_aurora_tx_arbiter.sv
module tb_aurora_tx_arbiter;

    localparam int DW = 16;
    localparam int NS = 4;
    localparam int LW = 8;

    logic              USER_CLK = 1'b0;
    logic              RESET;
    logic              CHANNEL_UP;
    logic [NS-1:0]     REQ;
    logic [NS*LW-1:0]  REQ_LEN;
    logic [NS-1:0]     GNT;
    logic [NS*DW-1:0]  SRC_D;
    logic [NS-1:0]     SRC_VALID;
    logic [NS-1:0]     SRC_POP;
    logic [0:DW-1]     TX_D;
    logic              TX_SRC_RDY_N;
    logic              TX_DST_RDY_N;
    logic              BURST_DONE;
    logic              BURST_ABORT;
    logic [3:0]        CUR_SRC;

    aurora_tx_arbiter #(.DATA_WIDTH(DW), .N_SRC(NS), .LEN_WIDTH(LW)) dut (
        .USER_CLK     (USER_CLK),
        .RESET        (RESET),
        .CHANNEL_UP   (CHANNEL_UP),
        .REQ          (REQ),
        .REQ_LEN      (REQ_LEN),
        .GNT          (GNT),
        .SRC_D        (SRC_D),
        .SRC_VALID    (SRC_VALID),
        .SRC_POP      (SRC_POP),
        .TX_D         (TX_D),
        .TX_SRC_RDY_N (TX_SRC_RDY_N),
        .TX_DST_RDY_N (TX_DST_RDY_N),
        .BURST_DONE   (BURST_DONE),
        .BURST_ABORT  (BURST_ABORT),
        .CUR_SRC      (CUR_SRC)
    );

    always #5 USER_CLK = ~USER_CLK;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard of expected TX words in link order.
    logic [15:0] sb_q[$];
    int seq[NS];
    int exp_seq[NS];

    function automatic logic [15:0] mk_word(input int s, input int n);
        return 16'h5000 | 16'((s & 15) << 8) | 16'(n & 255);
    endfunction

    function automatic logic [15:0] mk_hdr(input int s, input int len);
        return 16'hA000 | 16'((s & 15) << 8) | 16'(len & 255);
    endfunction

    task automatic push_burst(input int s, input int len, input int n_payload);
        sb_q.push_back(mk_hdr(s, len));
        for (int k = 0; k < n_payload; k++) begin
            sb_q.push_back(mk_word(s, exp_seq[s]));
            exp_seq[s]++;
        end
    endtask

    // Source models: each presents its next numbered word and advances on pop.
    initial for (int i = 0; i < NS; i++) begin seq[i] = 0; exp_seq[i] = 0; end
    always_comb begin
        SRC_D = '0;
        for (int i = 0; i < NS; i++) SRC_D[i*DW +: DW] = mk_word(i, seq[i]);
    end
    always @(posedge USER_CLK) begin
        for (int i = 0; i < NS; i++) if (SRC_POP[i]) seq[i] <= seq[i] + 1;
    end

    // Monitor
    int cyc = 0;
    int last_xfer_cyc = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    int pop_cnt[NS];
    int gnt_cyc[NS];
    int gnt_log[$];
    logic [NS-1:0] prev_gnt = '0;
    logic [15:0] txw;
    assign txw = TX_D;

    initial for (int i = 0; i < NS; i++) begin pop_cnt[i] = 0; gnt_cyc[i] = 0; end

    always @(posedge USER_CLK) cyc <= cyc + 1;

    always @(negedge USER_CLK) begin
        if (!TX_SRC_RDY_N && !TX_DST_RDY_N) begin
            if (sb_q.size() == 0) check("sb_extra_word", 1, 0);
            else check("tx_word", txw, sb_q.pop_front());
            last_xfer_cyc = cyc;
        end
        if (BURST_DONE) begin
            done_cnt++;
            check("done_latency", cyc - last_xfer_cyc, 1);
        end
        if (BURST_ABORT) abort_cnt++;
        for (int i = 0; i < NS; i++) begin
            if (SRC_POP[i]) pop_cnt[i]++;
            if (GNT[i]) gnt_cyc[i]++;
        end
        if (SRC_POP != '0) check("pop_in_gnt", SRC_POP & ~GNT, 0);
        if (GNT != prev_gnt) begin
            check("gnt_onehot0", 32'($onehot0(GNT)), 1);
            if (prev_gnt != '0 && GNT != '0) check("gnt_gap", 1, 0);
            if (prev_gnt == '0 && GNT != '0) gnt_log.push_back(int'(CUR_SRC));
        end
        prev_gnt = GNT;
    end

    task automatic tick();
        @(posedge USER_CLK);
        #1;
    endtask

    task automatic clear_counts();
        done_cnt  = 0;
        abort_cnt = 0;
        gnt_log.delete();
        for (int i = 0; i < NS; i++) begin pop_cnt[i] = 0; gnt_cyc[i] = 0; end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        REQ = '0;
        CHANNEL_UP = 1'b1;
        TX_DST_RDY_N = 1'b0;
        tick();
        tick();
        RESET = 1'b0;
        clear_counts();
    endtask

    task automatic wait_gnt(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (GNT != '0) seen = 1'b1;
            else tick();
        end
        if (!seen) check({tag, "_gnt_timeout"}, 1, 0);
    endtask

    task automatic wait_done(input string tag, input int n);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (done_cnt >= n) seen = 1'b1;
            else tick();
        end
        if (!seen) check({tag, "_done_timeout"}, done_cnt, n);
    endtask

    task automatic wait_pops(input string tag, input int s, input int n);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (pop_cnt[s] >= n) seen = 1'b1;
            else tick();
        end
        if (!seen) check({tag, "_pop_timeout"}, pop_cnt[s], n);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdy_n"}, TX_SRC_RDY_N, 1);
        check({tag, "_txd"},   txw, 0);
        check({tag, "_gnt"},   GNT, 0);
        check({tag, "_pop"},   SRC_POP, 0);
        check({tag, "_done"},  BURST_DONE, 0);
        check({tag, "_abort"}, BURST_ABORT, 0);
        check({tag, "_cur"},   CUR_SRC, 0);
    endtask

    initial begin
        int order[5] = '{0, 1, 2, 3, 0};
        int d0;
        int a0;
        RESET = 1'b1;
        CHANNEL_UP = 1'b1;
        REQ = '0;
        REQ_LEN = '0;
        SRC_VALID = '1;
        TX_DST_RDY_N = 1'b0;
        tick();
        tick();
        @(negedge USER_CLK);
        check_reset_outputs("rst");
        tick();
        RESET = 1'b0;
        clear_counts();

        // Single burst from source 0, length 3.
        REQ_LEN[0 +: LW] = 8'd3;
        push_burst(0, 3, 3);
        REQ = 4'b0001;
        wait_gnt("t1");
        check("t1_gnt", GNT, 4'b0001);
        REQ = '0;
        wait_done("t1", 1);
        check("t1_gnt_cycles", gnt_cyc[0], 4);
        check("t1_sb_drain", sb_q.size(), 0);

        // All sources request with length 1: round-robin order 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < NS; i++) REQ_LEN[i*LW +: LW] = 8'd1;
        for (int k = 0; k < 5; k++) push_burst(order[k], 1, 1);
        REQ = 4'b1111;
        for (int i = 0; i < 200 && gnt_log.size() < 5; i++) tick();
        REQ = '0;
        wait_done("t2", 5);
        check("t2_grants", gnt_log.size(), 5);
        if (gnt_log.size() >= 5)
            for (int k = 0; k < 5; k++) check("t2_order", gnt_log[k], order[k]);

        // Source 2, length 4, with destination stalls on header and payload.
        do_reset();
        REQ_LEN[2*LW +: LW] = 8'd4;
        TX_DST_RDY_N = 1'b1;
        push_burst(2, 4, 4);
        REQ = 4'b0100;
        wait_gnt("t3");
        REQ = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge USER_CLK);
            check("t3_hdr_hold", txw, 16'hA204);
            check("t3_hdr_rdy", TX_SRC_RDY_N, 0);
            check("t3_hdr_pop", SRC_POP, 0);
            tick();
        end
        TX_DST_RDY_N = 1'b0;
        tick();
        tick();
        tick();
        TX_DST_RDY_N = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge USER_CLK);
            check("t3_stall_pop", SRC_POP, 0);
            check("t3_stall_gnt", GNT, 4'b0100);
            tick();
        end
        TX_DST_RDY_N = 1'b0;
        wait_done("t3", 1);
        check("t3_pops", pop_cnt[2], 4);

        // Zero-length burst from source 1: header only.
        do_reset();
        REQ_LEN[1*LW +: LW] = 8'd0;
        push_burst(1, 0, 0);
        REQ = 4'b0010;
        wait_gnt("t4");
        REQ = '0;
        wait_done("t4", 1);
        check("t4_pops", pop_cnt[1], 0);
        check("t4_sb_drain", sb_q.size(), 0);

        // Channel loss after 2 of 5 payload words from source 0.
        do_reset();
        REQ_LEN[0 +: LW] = 8'd5;
        push_burst(0, 5, 2);
        REQ = 4'b0001;
        wait_gnt("t5");
        REQ = '0;
        wait_pops("t5", 0, 2);
        CHANNEL_UP = 1'b0;
        @(negedge USER_CLK);
        check("t5_drop_rdy", TX_SRC_RDY_N, 1);
        check("t5_drop_pop", SRC_POP, 0);
        tick();
        REQ_LEN[0 +: LW] = 8'd1;
        REQ_LEN[1*LW +: LW] = 8'd1;
        REQ = 4'b0011;
        @(negedge USER_CLK);
        check("t5_abort_gnt", GNT, 0);
        check("t5_abort_pulse", BURST_ABORT, 1);
        tick();
        @(negedge USER_CLK);
        check("t5_abort_single", BURST_ABORT, 0);
        check("t5_down_no_gnt", GNT, 0);
        tick();
        @(negedge USER_CLK);
        check("t5_down_no_gnt2", GNT, 0);
        tick();
        check("t5_abort_cnt", abort_cnt, 1);
        check("t5_no_done", done_cnt, 0);
        push_burst(1, 1, 1);
        CHANNEL_UP = 1'b1;
        wait_gnt("t5r");
        check("t5_next_src", CUR_SRC, 1);
        check("t5_next_gnt", GNT, 4'b0010);
        REQ = '0;
        wait_done("t5r", 1);

        // Reset in the middle of a source-2 burst.
        REQ_LEN[2*LW +: LW] = 8'd4;
        push_burst(2, 4, 2);
        REQ = 4'b0100;
        wait_gnt("t6");
        REQ = '0;
        wait_pops("t6", 2, 1);
        d0 = done_cnt;
        a0 = abort_cnt;
        RESET = 1'b1;
        tick();
        @(negedge USER_CLK);
        check_reset_outputs("t6_rst");
        tick();
        RESET = 1'b0;
        check("t6_no_done", done_cnt, d0);
        check("t6_no_abort", abort_cnt, a0);
        REQ_LEN[0 +: LW] = 8'd1;
        push_burst(0, 1, 1);
        REQ = 4'b0101;
        wait_gnt("t6r");
        check("t6_first_src", CUR_SRC, 0);
        REQ = '0;
        wait_done("t6r", d0 + 1);
        tick();
        check("sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
